// File: rtl/bn_pkg.sv
// Shared definitions for the batch-norm datapath: fixed-point format,
// the apply-stage state encoding and the output saturation helper.
package bn_pkg;

    localparam int BN_IL = 4;
    localparam int BN_FL = 16;
    localparam int W     = BN_IL + BN_FL;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Clamp a wide signed intermediate (2W+2 bits) to the W-bit signed range.
    // The value fits exactly when every bit from W-1 upward equals the sign.
    function automatic logic signed [W-1:0] sat_w(input logic signed [2*W+1:0] v);
        logic [W+2:0] upper;
        upper = v[2*W+1:W-1];
        if (upper == '0 || upper == '1)
            return v[W-1:0];
        else if (v[2*W+1])
            return {1'b1, {(W-1){1'b0}}};
        else
            return {1'b0, {(W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/bn_fx_affine.sv
// Combinational fixed-point affine kernel: y = sat((x - mean) * gamma >>> FL + beta).
// Kept free of state so later batch-norm stages can reuse it unchanged.
module bn_fx_affine
    import bn_pkg::*;
(
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] mean,
    input  logic signed [W-1:0] gamma,
    input  logic signed [W-1:0] beta,
    output logic signed [W-1:0] y
);

    logic signed [W:0]     d;
    logic signed [2*W:0]   p;
    logic signed [2*W:0]   q;
    logic signed [2*W+1:0] s;

    // Subtract, multiply, rescale and offset at widths that never overflow.
    always_comb begin
        d = {x[W-1], x} - {mean[W-1], mean};
        // |d * gamma| < 2^(2W), so the low 2W+1 bits of the product are exact.
        p = {{W{d[W]}}, d} * {{(W+1){gamma[W-1]}}, gamma};
        q = p >>> BN_FL;
        s = {q[2*W], q} + {{(W+2){beta[W-1]}}, beta};
        y = sat_w(s);
    end

endmodule

// File: rtl/bn_apply.sv
// Batch-norm apply stage: captures a parallel batch plus its statistics and
// streams normalized elements out one per ready/valid handshake, in order.
module bn_apply
    import bn_pkg::*;
#(
    parameter int IL   = BN_IL,
    parameter int FL   = BN_FL,
    parameter int size = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic signed [IL+FL-1:0]   batch [size-1:0],
    input  logic        [4:0]         num,
    input  logic signed [IL+FL-1:0]   mean,
    input  logic signed [IL+FL-1:0]   gamma,
    input  logic signed [IL+FL-1:0]   beta,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [IL+FL-1:0]   out_data,
    output logic        [4:0]         out_idx,
    output logic                      busy,
    output logic                      done
);

    localparam int         DW       = IL + FL;
    localparam int         IW       = (size > 1) ? $clog2(size) : 1;
    localparam logic [5:0] SIZE_CAP = 6'(size);

    state_t                state;
    logic signed [DW-1:0]  batch_r [size-1:0];
    logic signed [DW-1:0]  mean_r;
    logic signed [DW-1:0]  gamma_r;
    logic signed [DW-1:0]  beta_r;
    logic        [4:0]     n_r;
    logic        [4:0]     idx;
    logic        [4:0]     n_cap;
    logic signed [DW-1:0]  y;
    logic                  running;

    // Clip the requested length to the storage depth.
    always_comb begin
        n_cap = ({1'b0, num} > SIZE_CAP) ? SIZE_CAP[4:0] : num;
    end

    // Control FSM, element index and capture registers.
    // NOTE: state updates use non-blocking assignments so every register in
    // this block samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            n_r     <= '0;
            mean_r  <= '0;
            gamma_r <= '0;
            beta_r  <= '0;
            // NOTE: the captured batch is cleared on reset on purpose so a
            // reset leaves no stale operands visible; this costs a reset net
            // per flop, which is acceptable at this depth.
            for (int i = 0; i < size; i++) begin
                batch_r[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        batch_r <= batch;
                        mean_r  <= mean;
                        gamma_r <= gamma;
                        beta_r  <= beta;
                        n_r     <= n_cap;
                        idx     <= '0;
                        state   <= (n_cap == 5'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (idx == n_r - 5'd1) begin
                            idx   <= '0;
                            state <= DONE;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    bn_fx_affine u_affine (
        .x     (batch_r[idx[IW-1:0]]),
        .mean  (mean_r),
        .gamma (gamma_r),
        .beta  (beta_r),
        .y     (y)
    );

    // Outputs decode registered state only; data and index are forced to 0
    // whenever nothing is being offered.
    // NOTE: every output gets a value on every path through this block, so
    // no latch is inferred.
    always_comb begin
        running   = (state == RUN);
        out_valid = running;
        busy      = running;
        done      = (state == DONE);
        out_idx   = running ? idx : 5'd0;
        out_data  = running ? y : '0;
    end

endmodule

// File: tb/tb_bn_apply.sv
// Self-checking bench for bn_apply: a plain-arithmetic reference model feeds
// an expected-output queue that a per-cycle compare process drains, plus
// directed literal checks for latency, boundaries, backpressure and reset.
module tb_bn_apply;

    localparam int  FL   = 16;
    localparam int  SIZE = 16;
    localparam longint MAXV = 524287;
    localparam longint MINV = -524288;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic signed [19:0]  batch [SIZE-1:0];
    logic        [4:0]   num;
    logic signed [19:0]  mean;
    logic signed [19:0]  gamma;
    logic signed [19:0]  beta;
    logic                out_valid;
    logic                out_ready;
    logic signed [19:0]  out_data;
    logic        [4:0]   out_idx;
    logic                busy;
    logic                done;

    typedef struct {
        int     idx;
        longint data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    bn_apply dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .batch     (batch),
        .num       (num),
        .mean      (mean),
        .gamma     (gamma),
        .beta      (beta),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: exact real-valued affine map, floored to the output LSB, then clamped.
    function automatic longint model(input longint x, input longint m,
                                     input longint g, input longint b);
        longint p, q, s;
        p = (x - m) * g;
        q = p >>> FL;
        s = q + b;
        if (s > MAXV) s = MAXV;
        if (s < MINV) s = MINV;
        return s;
    endfunction

    task automatic set_ramp();
        for (int j = 0; j < SIZE; j++) batch[j] = 20'(5 * j + 8);
    endtask

    task automatic push_exp(input int nm, input longint m, input longint g, input longint b);
        int n_eff;
        exp_t e;
        n_eff = (nm > SIZE) ? SIZE : nm;
        for (int i = 0; i < n_eff; i++) begin
            e.idx  = i;
            e.data = model(longint'(batch[i]), m, g, b);
            exp_q.push_back(e);
        end
    endtask

    // Step into an IDLE cycle, present a batch and pulse start; returns at
    // edge+1 of the capture edge, i.e. inside cycle k+1.
    task automatic kick(input int nm, input longint m, input longint g,
                        input longint b, input bit hold);
        @(posedge clk); #1;
        num   = 5'(nm);
        mean  = 20'(m);
        gamma = 20'(g);
        beta  = 20'(b);
        start = 1'b1;
        @(posedge clk); #1;
        push_exp(nm, m, g, b);
        if (!hold) begin
            start = 1'b0;
            for (int j = 0; j < SIZE; j++) batch[j] = 20'($urandom);
            mean  = 20'($urandom);
            gamma = 20'($urandom);
            beta  = 20'($urandom);
            num   = 5'($urandom);
        end
    endtask

    // Consume a batch from cycle k+1 until done, optionally stalling at one index.
    task automatic drain(input string tag, input int n_exp, input int exp_done,
                         input int stall_idx, input int stall_len);
        int cyc, first, xfers, left, held_i;
        bit seen_done;
        logic signed [19:0] held_d;
        cyc = 1; first = -1; xfers = 0; left = stall_len; held_i = -1;
        seen_done = 1'b0; held_d = '0;
        while (cyc <= 300) begin
            if (out_valid) begin
                if (first < 0) first = cyc;
                if (left > 0 && int'(out_idx) == stall_idx) begin
                    if (held_i < 0) begin
                        held_i = int'(out_idx);
                        held_d = out_data;
                    end else begin
                        check({tag, "_stall_data"}, longint'(out_data), longint'(held_d));
                        check({tag, "_stall_idx"}, longint'(out_idx), longint'(held_i));
                    end
                    out_ready = 1'b0;
                    left--;
                end else begin
                    out_ready = 1'b1;
                end
                if (out_ready) xfers++;
            end else begin
                out_ready = 1'b1;
            end
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b1;
        check({tag, "_done_seen"}, longint'(seen_done), 1);
        check({tag, "_done_cycle"}, cyc, exp_done);
        check({tag, "_transfers"}, xfers, n_exp);
        check({tag, "_first_valid"}, first, (n_exp > 0) ? 1 : -1);
        check({tag, "_busy_at_done"}, longint'(busy), 0);
    endtask

    // Per-cycle comparison of the DUT against the expected-output queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            check("reset_valid", longint'(out_valid), 0);
            check("reset_data", longint'(out_data), 0);
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", longint'(out_idx), -1);
                end else begin
                    check("stream_idx", longint'(out_idx), exp_q[0].idx);
                    check("stream_data", longint'(out_data), exp_q[0].data);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                check("idle_data", longint'(out_data), 0);
                check("idle_idx", longint'(out_idx), 0);
            end
            check("busy_eq_valid", longint'(busy), longint'(out_valid));
            if (done) begin
                check("done_queue_empty", exp_q.size(), 0);
                check("done_no_valid", longint'(out_valid), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        num = '0; mean = '0; gamma = '0; beta = '0;
        for (int j = 0; j < SIZE; j++) batch[j] = '0;

        // Model pinned against hand-computed values.
        check("model_id_idx0", model(8, 30, 65536, 0), -22);
        check("model_id_idx9", model(53, 30, 65536, 0), 23);
        check("model_sc_idx0", model(8, 30, 131072, 65536), 65492);
        check("model_sc_idx9", model(53, 30, 131072, 65536), 65582);
        check("model_sat_hi", model(524287, -524288, 65536, 0), 524287);
        check("model_sat_lo", model(524287, -524288, -65536, 0), -524288);

        #1;
        check("por_valid", longint'(out_valid), 0);
        check("por_busy", longint'(busy), 0);
        check("por_done", longint'(done), 0);
        check("por_idx", longint'(out_idx), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Identity
        set_ramp();
        kick(10, 30, 65536, 0, 1'b0);
        check("id_first_data", longint'(out_data), -22);
        check("id_first_idx", longint'(out_idx), 0);
        drain("identity", 10, 11, -1, 0);

        // Scale and shift
        set_ramp();
        kick(10, 30, 131072, 65536, 1'b0);
        check("sc_first_data", longint'(out_data), 65492);
        drain("scale", 10, 11, -1, 0);

        // Saturation both directions
        batch[0] = 20'sd524287;
        kick(1, -524288, 65536, 0, 1'b0);
        check("sat_hi_data", longint'(out_data), 524287);
        drain("sat_hi", 1, 2, -1, 0);
        batch[0] = 20'sd524287;
        kick(1, -524288, -65536, 0, 1'b0);
        check("sat_lo_data", longint'(out_data), -524288);
        drain("sat_lo", 1, 2, -1, 0);

        // Backpressure at idx 2 for three cycles
        set_ramp();
        kick(10, 30, 65536, 0, 1'b0);
        drain("bp", 10, 14, 2, 3);

        // Empty batch and over-length batch
        kick(0, 0, 0, 0, 1'b0);
        check("n0_done_now", longint'(done), 1);
        drain("n0", 0, 1, -1, 0);
        set_ramp();
        kick(20, 30, 65536, 0, 1'b0);
        drain("n20", 16, 17, -1, 0);

        // Start held high through RUN and DONE
        set_ramp();
        kick(10, 30, 65536, 0, 1'b1);
        drain("hold1", 10, 11, -1, 0);
        @(posedge clk); #1;
        check("hold_idle_valid", longint'(out_valid), 0);
        check("hold_idle_done", longint'(done), 0);
        push_exp(10, 30, 65536, 0);
        @(posedge clk); #1;
        check("hold_restart_valid", longint'(out_valid), 1);
        check("hold_restart_idx", longint'(out_idx), 0);
        start = 1'b0;
        drain("hold2", 10, 11, -1, 0);

        // Reset in the middle of a batch
        set_ramp();
        kick(10, 30, 65536, 0, 1'b0);
        k = 0;
        while (k < 20 && !(out_valid && out_idx == 5'd4)) begin
            @(posedge clk); #1;
            k++;
        end
        check("rst_reached_idx4", longint'(out_idx), 4);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", longint'(out_valid), 0);
        check("rst_async_data", longint'(out_data), 0);
        check("rst_async_idx", longint'(out_idx), 0);
        check("rst_async_busy", longint'(busy), 0);
        check("rst_async_done", longint'(done), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_no_done", longint'(done), 0);
        end
        set_ramp();
        kick(10, 30, 65536, 0, 1'b0);
        check("rst_fresh_idx", longint'(out_idx), 0);
        check("rst_fresh_data", longint'(out_data), -22);
        drain("after_rst", 10, 11, -1, 0);

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
